spi_host_master: RTL and testbench
==================================

Name: spi_host_master

Overview:
- Upstream SPI master that drives the SPI_Wrapper slave pins: SS_n, MOSI, MISO.
- Accepts one command per handshake from a host-side requester: a 2-bit cmd plus 8-bit payload.
- Serializes each command as a framed SPI transaction, one bit per clk.
- For cmd 2'b11 (read data), keeps SS_n low and deserializes the 8-bit read byte returned on MISO.

Parameters:
- RD_LAT, 2: clk cycles between the last frame bit and the first MISO sample on a read-data transaction (slave tx_valid turnaround).
- GAP_CYCLES, 3: minimum clk cycles SS_n stays high between transactions.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request valid; accepted only when ready=1.
- cmd  in  2  00 write addr, 01 write data, 10 read addr, 11 read data.
- din  in  8  address or data payload; dummy for cmd 11.
- ready  out  1  high when idle and gap elapsed.
- busy  out  1  high from acceptance until SS_n returns high.
- rd_data  out  8  last captured read byte.
- rd_valid  out  1  one-cycle pulse when rd_data updates.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset (rst_n=0 at posedge): SS_n=1, MOSI=0, ready=1, busy=0, rd_valid=0, rd_data=8'h00, state IDLE, counters 0.
- Reset mid-transaction: abort at that edge; SS_n=1 with no trailing bits. No rd_valid is issued, and rd_data keeps its reset value.
- Acceptance: start && ready at posedge latches frame = {cmd[1], cmd[1], cmd[0], din[7:0]} (11 bits). Then ready=0 and busy=1.
- start while ready=0 is ignored; there is no queueing.
- All outputs are registered and change only on posedge.
- States: IDLE, LEAD, SHIFT, WAIT, CAPTURE, GAP.
- IDLE: on acceptance, go to LEAD.
  - SS_n=1 and MOSI=0.
- LEAD: one cycle with SS_n=0 and MOSI=0, letting the slave move IDLE->CHK_CMD.
- SHIFT: 11 cycles. Cycle k drives frame[10-k] on MOSI, MSB first; SS_n stays 0.
  - After cycle 10: cmd 11 goes to WAIT.
  - After cycle 10: any other cmd goes to GAP with SS_n=1.
- WAIT: RD_LAT cycles, SS_n=0, MOSI=0.
- CAPTURE: 8 cycles, SS_n=0.
  - Each posedge samples MISO into a shift register, MSB first.
  - After the 8th sample: rd_data = shifted byte, rd_valid=1 for one cycle, SS_n=1, go to GAP.
- GAP: SS_n=1 for GAP_CYCLES cycles, then IDLE, ready=1, busy=0.
  - busy=1 from LEAD through the last SS_n-low cycle, then 0.
  - ready stays 0 through GAP.
- Transaction length, SS_n low:
  - Non-read: 1 + 11 = 12 cycles.
  - cmd 11: 12 + RD_LAT + 8 cycles.
- start asserted in the same cycle ready rises is accepted.
- The master does not track read-addr-before-read-data ordering. The host owns sequencing.

Optional Feature:
- Macro SPI_MASTER_MISO_SYNC_EN.
- Defined:
  - MISO passes through a 2-flop synchronizer before sampling.
  - WAIT lasts RD_LAT+2 cycles, so captured bits stay aligned.
  - A cmd-11 SS_n-low window grows by 2 cycles.
- Undefined:
  - MISO is sampled directly.
  - WAIT lasts exactly RD_LAT cycles.

Test Plan:
- Reset then start cmd=00 din=8'hA5 -> SS_n low for exactly 12 cycles. MOSI after LEAD = 0,0,0,1,0,1,0,0,1,0,1. SS_n then high for 3 cycles before ready=1.
- start cmd=01 din=8'h3C, then cmd=10 din=8'hA5, then cmd=11 against SPI_Wrapper -> rd_valid pulses once with rd_data=8'h3C. SS_n low 22 cycles on the read.
- Repeat the full sequence with address 8'h69 and data 8'hFF -> rd_data=8'hFF. The read frame MOSI prefix is 1,1,1.
- Pulse start during SHIFT of an active transaction -> ignored. Exactly one transaction is observed, and ready stays 0 until GAP ends.
- Assert rst_n=0 mid-CAPTURE -> next edge SS_n=1, MOSI=0, no rd_valid, rd_data=8'h00, ready=1.
- With SPI_MASTER_MISO_SYNC_EN defined, model slave driving 8'hC3 -> rd_data=8'hC3, SS_n low 24 cycles.

Source files
------------

// File: rtl/spi_host_master_if.sv
// spi_host_master_if: host command handshake, read-back and SPI pin bundle
interface spi_host_master_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] din;
    logic       ready;
    logic       busy;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    modport master (
        input  start, cmd, din, MISO,
        output ready, busy, rd_data, rd_valid, SS_n, MOSI
    );
    modport slave (
        output start, cmd, din, MISO,
        input  ready, busy, rd_data, rd_valid, SS_n, MOSI
    );
endinterface

// File: rtl/spi_host_master.sv
// spi_host_master: framed SPI master for SPI_Wrapper; SPI_MASTER_MISO_SYNC_EN adds a 2-flop MISO synchronizer
module spi_host_master #(
    parameter int RD_LAT     = 2,
    parameter int GAP_CYCLES = 3
) (
    input logic              clk,
    input logic              rst_n,
    spi_host_master_if.master bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LEAD    = 3'd1;
    localparam logic [2:0] SHIFT   = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] CAPTURE = 3'd4;
    localparam logic [2:0] GAP     = 3'd5;
    logic       miso_s;
`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam logic [7:0] WAIT_LAST = 8'(RD_LAT + 1);
    logic [1:0] miso_sync;
    always_ff @(posedge clk) begin
        if (!rst_n) miso_sync <= 2'b00;
        else        miso_sync <= {miso_sync[0], bus.MISO};
    end
    assign miso_s = miso_sync[1];
`else
    localparam logic [7:0] WAIT_LAST = 8'(RD_LAT - 1);
    assign miso_s = bus.MISO;
`endif
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    logic [2:0]  state;
    logic [7:0]  cnt;
    logic [10:0] frame;
    logic [7:0]  shreg;
    logic        rd_cmd;
    logic        ss_n_q, mosi_q, ready_q, busy_q, rd_valid_q;
    logic [7:0]  rd_data_q;
    assign bus.SS_n     = ss_n_q;
    assign bus.MOSI     = mosi_q;
    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    // frame shifts left so the bit to send next is always frame[10]
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            frame      <= 11'd0;
            shreg      <= 8'd0;
            rd_cmd     <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'd0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && ready_q) begin
                        frame   <= {bus.cmd[1], bus.cmd, bus.din};
                        rd_cmd  <= &bus.cmd;
                        state   <= LEAD;
                        ss_n_q  <= 1'b0;
                        mosi_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                LEAD: begin
                    state  <= SHIFT;
                    cnt    <= 8'd0;
                    mosi_q <= frame[10];
                    frame  <= {frame[9:0], 1'b0};
                end
                SHIFT: begin
                    if (cnt == 8'd10) begin
                        cnt    <= 8'd0;
                        mosi_q <= 1'b0;
                        state  <= rd_cmd ? WAIT : GAP;
                        ss_n_q <= ~rd_cmd;
                        busy_q <= rd_cmd;
                    end else begin
                        cnt    <= cnt + 8'd1;
                        mosi_q <= frame[10];
                        frame  <= {frame[9:0], 1'b0};
                    end
                end
                WAIT: begin
                    state <= (cnt == WAIT_LAST) ? CAPTURE : WAIT;
                    cnt   <= (cnt == WAIT_LAST) ? 8'd0 : cnt + 8'd1;
                end
                CAPTURE: begin
                    shreg <= {shreg[6:0], miso_s};
                    if (cnt == 8'd7) begin
                        rd_data_q  <= {shreg[6:0], miso_s};
                        rd_valid_q <= 1'b1;
                        ss_n_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= GAP;
                        cnt        <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        cnt     <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_host_master.sv
// tb_spi_host_master: directed vectors against a behavioural SPI_Wrapper slave model
module tb_spi_host_master;
    localparam int RD_LAT = 2;
    localparam int GAPC   = 3;
`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int RDLOW = 20 + RD_LAT + SYNC;
    typedef struct {
        logic [1:0] cmd;
        logic [7:0] din;
        int         exp_low;
        int         exp_rv;
        logic [7:0] exp_rd;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    spi_host_master_if bus();
    spi_host_master #(.RD_LAT(RD_LAT), .GAP_CYCLES(GAPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    int          m_n = 0;
    logic [9:0]  m_rx = '0;
    logic [10:0] m_frame = '0;
    logic        m_lead = 1'b0;
    logic [7:0]  m_wa = '0, m_ra = '0, m_tx = '0;
    logic [7:0]  m_mem [256];
    wire  [10:0] m_f = {m_rx, bus.MOSI};
    // slave model: bit k of the frame is on MOSI in SS_n-low cycle k+1; read byte leaves in cycles 12+RD_LAT..
    always @(negedge clk) begin
        if (bus.SS_n) begin
            m_n      <= 0;
            bus.MISO <= 1'b0;
        end else begin
            m_n <= m_n + 1;
            if (m_n == 0) m_lead <= bus.MOSI;
            if (m_n >= 1 && m_n <= 10) m_rx <= {m_rx[8:0], bus.MOSI};
            if (m_n == 11) begin
                m_frame <= m_f;
                case (m_f[10:8])
                    3'b000:  m_wa <= m_f[7:0];
                    3'b001:  m_mem[m_wa] <= m_f[7:0];
                    3'b110:  m_ra <= m_f[7:0];
                    3'b111:  m_tx <= m_mem[m_ra];
                    default: ;
                endcase
            end
            if (m_n >= 12 + RD_LAT && m_n < 20 + RD_LAT) bus.MISO <= m_tx[7 - (m_n - 12 - RD_LAT)];
            else bus.MISO <= 1'b0;
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask
    task automatic run(input logic [1:0] cmd, input logic [7:0] din,
                       output int low, output int gap, output int rv, output int busy_bad);
        int t;
        t = 0;
        low = 0; gap = 0; rv = 0; busy_bad = 0;
        while (!bus.ready && t < 200) begin @(negedge clk); t++; end
        chk("ready_wait", 32'(t < 200), 32'd1);
        bus.start = 1'b1; bus.cmd = cmd; bus.din = din;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.SS_n && low < 100) begin
            low++;
            if (!bus.busy) busy_bad++;
            rv += int'(bus.rd_valid);
            @(negedge clk);
        end
        while (!bus.ready && gap < 100) begin
            gap++;
            if (bus.busy) busy_bad++;
            rv += int'(bus.rd_valid);
            @(negedge clk);
        end
    endtask
    vec_t v [12];
    initial begin
        int low, gap, rv, bb, falls, first_ready;
        logic prev_ss;
        v[0]  = '{2'b00, 8'hA5, 12,    0, 8'h00};
        v[1]  = '{2'b01, 8'h3C, 12,    0, 8'h00};
        v[2]  = '{2'b10, 8'hA5, 12,    0, 8'h00};
        v[3]  = '{2'b11, 8'h00, RDLOW, 1, 8'h3C};
        v[4]  = '{2'b00, 8'h69, 12,    0, 8'h00};
        v[5]  = '{2'b01, 8'hFF, 12,    0, 8'h00};
        v[6]  = '{2'b10, 8'h69, 12,    0, 8'h00};
        v[7]  = '{2'b11, 8'h5A, RDLOW, 1, 8'hFF};
        v[8]  = '{2'b00, 8'hC3, 12,    0, 8'h00};
        v[9]  = '{2'b01, 8'hC3, 12,    0, 8'h00};
        v[10] = '{2'b10, 8'hC3, 12,    0, 8'h00};
        v[11] = '{2'b11, 8'h00, RDLOW, 1, 8'hC3};
        bus.start = 1'b0; bus.cmd = 2'b00; bus.din = 8'h00;
        repeat (3) @(negedge clk);
        n_vec++;
        chk("rst_ss_n", 32'(bus.SS_n), 32'd1);
        chk("rst_mosi", 32'(bus.MOSI), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'h00);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            run(v[i].cmd, v[i].din, low, gap, rv, bb);
            chk($sformatf("v%0d_low", i), 32'(low), 32'(v[i].exp_low));
            chk($sformatf("v%0d_gap", i), 32'(gap), 32'(GAPC));
            chk($sformatf("v%0d_rd_valid", i), 32'(rv), 32'(v[i].exp_rv));
            chk($sformatf("v%0d_busy", i), 32'(bb), 32'd0);
            chk($sformatf("v%0d_lead_mosi", i), 32'(m_lead), 32'd0);
            chk($sformatf("v%0d_frame", i), 32'(m_frame), 32'({v[i].cmd[1], v[i].cmd, v[i].din}));
            if (v[i].exp_rv != 0) chk($sformatf("v%0d_rd_data", i), 32'(bus.rd_data), 32'(v[i].exp_rd));
        end
        // start pulsed during SHIFT must not start a second transaction
        n_vec++;
        bus.start = 1'b1; bus.cmd = 2'b00; bus.din = 8'h12;
        @(negedge clk);
        low = 0; falls = 0; first_ready = -1; prev_ss = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus.start = (c >= 4 && c < 6);
            bus.cmd = 2'b01; bus.din = 8'hFF;
            if (!bus.SS_n) low++;
            if (!bus.SS_n && prev_ss) falls++;
            if (bus.ready && first_ready < 0) first_ready = c;
            prev_ss = bus.SS_n;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("ign_falls", 32'(falls), 32'd1);
        chk("ign_low", 32'(low), 32'd12);
        chk("ign_first_ready", 32'(first_ready), 32'(12 + GAPC));
        chk("ign_frame", 32'(m_frame), 32'h012);
        // reset in the middle of CAPTURE
        n_vec++;
        run(2'b00, 8'h20, low, gap, rv, bb);
        run(2'b01, 8'h77, low, gap, rv, bb);
        run(2'b10, 8'h20, low, gap, rv, bb);
        bus.start = 1'b1; bus.cmd = 2'b11; bus.din = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12 + RD_LAT + SYNC + 3) @(negedge clk);
        chk("mid_in_capture_ss_n", 32'(bus.SS_n), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ss_n", 32'(bus.SS_n), 32'd1);
        chk("mid_rst_mosi", 32'(bus.MOSI), 32'd0);
        chk("mid_rst_ready", 32'(bus.ready), 32'd1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("mid_rst_rd_data", 32'(bus.rd_data), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        rv = 0; low = 0;
        repeat (30) begin
            @(negedge clk);
            rv += int'(bus.rd_valid);
            if (!bus.SS_n) low++;
        end
        chk("post_rst_rd_valid", 32'(rv), 32'd0);
        chk("post_rst_ss_low", 32'(low), 32'd0);
        chk("post_rst_rd_data", 32'(bus.rd_data), 32'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
